sevseg_fx_sequencer: RTL and testbench
======================================

# sevseg_fx_sequencer

Sequencer and scheduler for the seven-segment effect pattern decoders. It generates the 3-bit step index (`o_count`) that drives the pattern lookup modules, and it selects the active pattern (`o_sel`) for the downstream pattern mux. A programmable prescaler sets the animation rate. Pattern changes and stop requests take effect only at sequence boundaries, so the display never shows a truncated animation.

## Interface

**Parameters**
- `PRESCALE_W`, default 16: prescaler counter width. Must be ≥ 8.
- `COUNT_MAX`, default 7: last step index. Fixed at 7; the sequence is 8 steps.

**Ports**
- `i_clk`  in  1: the block's single clock.
- `i_rst_n`  in  1: reset. Asynchronous, active-low.
- `i_run`  in  1: level. High means animate; low means stop at the next wrap.
- `i_mode`  in  2: requested pattern. 0 = cw0, 1 = ccw0, 2 = cw1, 3 = ccw1.
- `i_speed`  in  3: rate select. Step period is 2^(PRESCALE_W-7+i_speed) cycles.
- `i_step`  in  1: single-cycle pulse. Manual advance, honoured only in IDLE.
- `o_count`  out  3: step index to the pattern decoders.
- `o_sel`  out  2: latched pattern select.
- `o_tick`  out  1: one-cycle pulse, high in the cycle `o_count` shows a new value.
- `o_wrap`  out  1: one-cycle pulse, high in the cycle `o_count` returns from 7 to 0.
- `o_active`  out  1: high in RUN or DRAIN.

## Operation

**Reset values:** state = IDLE, prescaler = 0, `o_count` = 0, `o_sel` = 0, `o_tick` = 0, `o_wrap` = 0, `o_active` = 0.

**State machine:** IDLE, RUN, DRAIN.
- **IDLE → RUN** when `i_run` = 1. On entry: `o_sel` ← `i_mode`, prescaler cleared, `o_count` held.
- **RUN → DRAIN** when `i_run` = 0.
- **DRAIN → RUN** when `i_run` = 1. No restart: the count and prescaler continue.
- **DRAIN → IDLE** on the step that wraps 7 → 0. In IDLE the count rests at 0.

**Prescaler:**
- Active in RUN and DRAIN only.
- Terminal value T = 2^(PRESCALE_W-7+i_speed) − 1, with `i_speed` read live.
- Step event when prescaler ≥ T. On a step event the prescaler clears; otherwise it increments.
- Lowering `i_speed` mid-period therefore fires a step on the next cycle.

**Step event:**
- `o_count` ← (`o_count` + 1) mod 8.
- `o_tick` is asserted for one cycle.
- On the 7 → 0 transition, `o_wrap` is asserted and `o_sel` ← `i_mode`. This is the only point at which `o_sel` changes outside IDLE entry.

**Manual step:** in IDLE, each `i_step` pulse advances `o_count` by 1 mod 8 and pulses `o_tick`. `o_sel` is not updated.

**Simultaneous events:**
- `i_step` and `i_run` in the same IDLE cycle: run wins and the step is dropped.
- `i_step` in RUN or DRAIN is ignored.

**Mid-operation reset:** asserting `i_rst_n` low returns everything to reset values immediately (asynchronously), whatever the state.

## Timing

- All outputs are registered. There is no combinational path from any input to any output.
- With PRESCALE_W = 8, T = 2^(1+i_speed) − 1, so `i_speed` = 0 gives one step every 2 cycles.
- RUN entry sampled at edge E0: the prescaler is 0 after E0, and the first step lands at edge E0 + 2^(PRESCALE_W-7+i_speed). `o_tick` is high in the following cycle.
- Manual step sampled at edge E: `o_count` updates at E, and `o_tick` is high in the cycle after E.
- `o_sel` latency from `i_mode`: up to one full sequence, 8 periods.
- Stop latency from `i_run` falling: up to 8 periods. `o_active` falls in the same cycle that `o_wrap` pulses.

## Structure

- **Shared package `sevseg_fx_pkg`:**
  - mode encodings MODE_CW0/CCW0/CW1/CCW1
  - state enum IDLE/RUN/DRAIN
  - COUNT_MAX
- **Sub-module `sevseg_prescaler`:**
  - inputs: enable, clear, `i_speed`
  - output: step pulse
  - parameterised by PRESCALE_W
- The FSM, step counter and select latch live in the top.

## Test plan

All scenarios use PRESCALE_W = 8.

- **Reset:** hold `i_rst_n` low for 3 cycles → all outputs 0 and state IDLE. Release with `i_run` = 0 → outputs stay 0 for 20 cycles.
- **Free run:** `i_run` = 1, `i_speed` = 0, `i_mode` = 1 → `o_sel` = 1 from entry, `o_count` steps 0,1,…,7,0 every 2 cycles, `o_tick` every 2nd cycle, `o_wrap` exactly once per 16 cycles. With `i_speed` = 2 → one step per 8 cycles.
- **Deferred mode change:** running with mode 0, set `i_mode` = 3 while count = 3 → `o_sel` stays 0 through count 7, becomes 3 in the `o_wrap` cycle.
- **Drain:** drop `i_run` at count 5 → counts 6, 7, 0 continue at the same rate, then `o_active` = 0 and the count holds 0 for 30 cycles. Re-raise `i_run` during DRAIN at count 6 → no stop, sequence continues.
- **Manual step:** three `i_step` pulses in IDLE → `o_count` = 3 with three `o_tick` pulses and `o_sel` unchanged. `i_step` together with `i_run` → the count is not advanced that cycle and the block enters RUN.
- **Async reset mid-run:** pull `i_rst_n` low at count 4 between clock edges → outputs are 0 before the next edge. After release the block is in IDLE.

Source files
------------

// File: rtl/sevseg_fx_pkg.sv
// Shared encodings for the seven-segment effect sequencer.
package sevseg_fx_pkg;

  // Last step index; every animation sequence is COUNT_MAX+1 steps long.
  localparam int COUNT_MAX = 7;

  typedef enum logic [1:0] {
    MODE_CW0  = 2'd0,
    MODE_CCW0 = 2'd1,
    MODE_CW1  = 2'd2,
    MODE_CCW1 = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sevseg_prescaler.sv
// Programmable animation-rate prescaler: emits one step every 2^(PRESCALE_W-7+i_speed) enabled cycles.
module sevseg_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic [2:0] i_speed,
  output logic       step
);

  logic [PRESCALE_W-1:0] cnt;

  // Terminal value 2^(PRESCALE_W-7+spd)-1; for spd = 7 this is all ones, so it always fits.
  function automatic logic [PRESCALE_W-1:0] terminal(input logic [2:0] spd);
    logic [PRESCALE_W:0] one_hot;
    int                  sh;
    sh          = PRESCALE_W - 7 + int'(spd);
    one_hot     = '0;
    one_hot[sh] = 1'b1;
    return PRESCALE_W'(one_hot - 1'b1);
  endfunction

  // Compare is ">=" against a live speed, so a lowered speed fires on the next cycle.
  assign step = enable && (cnt >= terminal(i_speed));

  // Period counter: cleared on run entry, free-running while enabled, held otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= step ? '0 : cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/sevseg_fx_sequencer.sv
// Step-index sequencer and pattern scheduler for the seven-segment effect decoders.
// Pattern and stop requests are honoured only at sequence wrap, never mid-animation.
module sevseg_fx_sequencer
  import sevseg_fx_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int COUNT_MAX  = 7
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  input  logic [1:0] i_mode,
  input  logic [2:0] i_speed,
  input  logic       i_step,
  output logic [2:0] o_count,
  output logic [1:0] o_sel,
  output logic       o_tick,
  output logic       o_wrap,
  output logic       o_active
);

  state_t state;
  state_t state_next;
  logic   step;
  logic   presc_en;
  logic   presc_clr;
  logic   man_step;
  logic   advance;
  logic   at_max;

  assign at_max    = (o_count == 3'(COUNT_MAX));
  assign presc_en  = (state != IDLE);
  // Entering RUN restarts the period so the first step is a full period away.
  assign presc_clr = (state == IDLE) && i_run;
  // A run request in the same cycle wins over a manual step.
  assign man_step  = (state == IDLE) && i_step && !i_run;
  assign advance   = step || man_step;

  sevseg_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .enable  (presc_en),
    .clear   (presc_clr),
    .i_speed (i_speed),
    .step    (step)
  );

  // Next-state logic: DRAIN finishes only on the step that wraps the count.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_run) state_next = RUN;
      RUN:     if (!i_run) state_next = DRAIN;
      DRAIN: begin
        if (i_run) begin
          state_next = RUN;
        end else if (step && at_max) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs: step counter, select latch and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count  <= '0;
      o_sel    <= '0;
      o_tick   <= 1'b0;
      o_wrap   <= 1'b0;
      o_active <= 1'b0;
    end else begin
      o_tick   <= advance;
      o_wrap   <= advance && at_max;
      o_active <= (state_next != IDLE);
      if (advance) begin
        o_count <= at_max ? 3'd0 : o_count + 3'd1;
      end
      // Manual steps never reload the select; only run entry and timed wraps do.
      if (presc_clr || (step && at_max)) begin
        o_sel <= i_mode;
      end
    end
  end

endmodule

// File: tb/tb_sevseg_fx_sequencer.sv
// Self-checking bench for sevseg_fx_sequencer (PRESCALE_W = 8).
module tb_sevseg_fx_sequencer;

  localparam int PW = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [1:0] mode;
  logic [2:0] speed;
  logic       step;
  logic [2:0] count;
  logic [1:0] sel;
  logic       tick;
  logic       wrap;
  logic       active;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sevseg_fx_sequencer #(
    .PRESCALE_W(PW),
    .COUNT_MAX (7)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_run   (run),
    .i_mode  (mode),
    .i_speed (speed),
    .i_step  (step),
    .o_count (count),
    .o_sel   (sel),
    .o_tick  (tick),
    .o_wrap  (wrap),
    .o_active(active)
  );

  // Reset hold and quiet idle after release.
  task automatic test_reset();
    run = 1'b0; mode = 2'd0; speed = 3'd0; step = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({count, sel, tick, wrap, active} !== 8'd0) begin
      bad++;
      $display("FAIL reset_hold: got count=%0d sel=%0d tick=%b wrap=%b active=%b, want all 0",
               count, sel, tick, wrap, active);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({count, sel, tick, wrap, active} !== 8'd0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d: got count=%0d sel=%0d tick=%b wrap=%b active=%b, want all 0",
                 i, count, sel, tick, wrap, active);
      end
    end
  endtask

  // Run from IDLE (count 0) at speed s, drop run after cycle drop_k, then watch the drain and idle.
  // Reference: k cycles after run entry, floor(k/p) steps have happened; stop is the first
  // sequence boundary (multiple of 8p) strictly after the edge that first sees run low.
  task automatic test_free_run(input logic [1:0] m, input int s, input int drop_k, input bit flip);
    int         p, kd, kstop, ec;
    logic       et, ew, ea;
    logic [1:0] exp_sel;
    p       = 1 << (1 + s);
    kd      = drop_k + 1;
    kstop   = (kd / (8 * p) + 1) * 8 * p;
    exp_sel = m;
    mode = m; speed = 3'(s); run = 1'b1; step = 1'b0;
    @(negedge clk);
    for (int k = 0; k <= kstop + 30; k++) begin
      if (k <= kstop) begin
        ec = (k / p) % 8;
        et = (k > 0) && (k % p == 0);
        ew = et && (ec == 0);
        ea = (k < kstop);
      end else begin
        ec = 0; et = 1'b0; ew = 1'b0; ea = 1'b0;
      end
      if (ew) exp_sel = mode;
      total++;
      if (count !== 3'(ec) || tick !== et || wrap !== ew || active !== ea || sel !== exp_sel) begin
        bad++;
        $display("FAIL free_run m=%0d s=%0d k=%0d: got count=%0d tick=%b wrap=%b active=%b sel=%0d, want count=%0d tick=%b wrap=%b active=%b sel=%0d",
                 m, s, k, count, tick, wrap, active, sel, ec, et, ew, ea, exp_sel);
      end
      if (k == drop_k) run = 1'b0;
      if (flip && k < kstop) begin
        if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
        step = 1'($urandom_range(0, 1));
      end else begin
        step = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // Mode request at count 3 is deferred to the wrap.
  task automatic test_mode_change();
    int         k;
    logic [1:0] exp_sel;
    mode = 2'd0; speed = 3'd0; run = 1'b1; step = 1'b0;
    @(negedge clk);
    for (k = 0; k <= 17; k++) begin
      exp_sel = (k >= 16) ? 2'd3 : 2'd0;
      total++;
      if (sel !== exp_sel || count !== 3'((k / 2) % 8) || wrap !== (k == 16)) begin
        bad++;
        $display("FAIL mode_change k=%0d: got sel=%0d count=%0d wrap=%b, want sel=%0d count=%0d wrap=%b",
                 k, sel, count, wrap, exp_sel, (k / 2) % 8, (k == 16));
      end
      if (k == 6) mode = 2'd3;
      if (k < 17) @(negedge clk);
    end
    k = 17; run = 1'b0;
    while (active === 1'b1 && k < 60) begin @(negedge clk); k++; end
    total++;
    if (k != 32 || count !== 3'd0 || wrap !== 1'b1 || sel !== 2'd3) begin
      bad++;
      $display("FAIL mode_change_stop: got stop_k=%0d count=%0d wrap=%b sel=%0d, want stop_k=32 count=0 wrap=1 sel=3",
               k, count, wrap, sel);
    end
    repeat (2) @(negedge clk);
  endtask

  // Lowering speed mid-period fires a step on the very next edge.
  task automatic test_speed_change();
    int k;
    mode = 2'd1; speed = 3'd2; run = 1'b1; step = 1'b0;
    @(negedge clk);
    for (k = 0; k <= 8; k++) begin
      total++;
      if (count !== ((k < 6) ? 3'd0 : (k < 8) ? 3'd1 : 3'd2) || tick !== (k == 6 || k == 8)) begin
        bad++;
        $display("FAIL speed_change k=%0d: got count=%0d tick=%b, want count=%0d tick=%b",
                 k, count, tick, (k < 6) ? 0 : (k < 8) ? 1 : 2, (k == 6 || k == 8));
      end
      if (k == 5) speed = 3'd0;
      if (k < 8) @(negedge clk);
    end
    k = 8; run = 1'b0;
    while (active === 1'b1 && k < 60) begin @(negedge clk); k++; end
    total++;
    if (k != 20 || count !== 3'd0 || wrap !== 1'b1) begin
      bad++;
      $display("FAIL speed_change_stop: got stop_k=%0d count=%0d wrap=%b, want stop_k=20 count=0 wrap=1",
               k, count, wrap);
    end
    repeat (2) @(negedge clk);
  endtask

  // Drop run at count 5, re-raise at count 6: the sequence carries on without stopping.
  task automatic test_drain_reraise();
    int k;
    mode = 2'd2; speed = 3'd0; run = 1'b1; step = 1'b0;
    @(negedge clk);
    for (k = 0; k <= 20; k++) begin
      total++;
      if (active !== 1'b1 || count !== 3'((k / 2) % 8) || tick !== (k > 0 && k % 2 == 0)) begin
        bad++;
        $display("FAIL drain_reraise k=%0d: got active=%b count=%0d tick=%b, want active=1 count=%0d tick=%b",
                 k, active, count, tick, (k / 2) % 8, (k > 0 && k % 2 == 0));
      end
      if (k == 10) run = 1'b0;
      if (k == 12) run = 1'b1;
      if (k < 20) @(negedge clk);
    end
    k = 20; run = 1'b0;
    while (active === 1'b1 && k < 60) begin @(negedge clk); k++; end
    total++;
    if (k != 32 || count !== 3'd0 || sel !== 2'd2) begin
      bad++;
      $display("FAIL drain_reraise_stop: got stop_k=%0d count=%0d sel=%0d, want stop_k=32 count=0 sel=2",
               k, count, sel);
    end
    repeat (2) @(negedge clk);
  endtask

  // Three manual steps in IDLE; select is untouched.
  task automatic test_manual_step(input logic [1:0] exp_sel);
    mode = 2'd0; run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      @(negedge clk);
      total++;
      if (count !== 3'(i + 1) || tick !== 1'b1 || sel !== exp_sel || active !== 1'b0) begin
        bad++;
        $display("FAIL manual_step n=%0d: got count=%0d tick=%b sel=%0d active=%b, want count=%0d tick=1 sel=%0d active=0",
                 i, count, tick, sel, active, i + 1, exp_sel);
      end
      step = 1'b0;
      @(negedge clk);
      total++;
      if (count !== 3'(i + 1) || tick !== 1'b0) begin
        bad++;
        $display("FAIL manual_step_gap n=%0d: got count=%0d tick=%b, want count=%0d tick=0",
                 i, count, tick, i + 1);
      end
    end
  endtask

  // Step and run together: run wins, count held at 3, then timed stepping resumes.
  task automatic test_step_with_run();
    step = 1'b1; run = 1'b1; mode = 2'd1; speed = 3'd0;
    @(negedge clk);
    step = 1'b0;
    total++;
    if (count !== 3'd3 || tick !== 1'b0 || active !== 1'b1 || sel !== 2'd1) begin
      bad++;
      $display("FAIL step_with_run: got count=%0d tick=%b active=%b sel=%0d, want count=3 tick=0 active=1 sel=1",
               count, tick, active, sel);
    end
    repeat (2) @(negedge clk);
    total++;
    if (count !== 3'd4 || tick !== 1'b1) begin
      bad++;
      $display("FAIL step_with_run_next: got count=%0d tick=%b, want count=4 tick=1", count, tick);
    end
  endtask

  // Asynchronous reset between edges while running at count 4.
  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({count, sel, tick, wrap, active} !== 8'd0) begin
      bad++;
      $display("FAIL async_reset: got count=%0d sel=%0d tick=%b wrap=%b active=%b, want all 0",
               count, sel, tick, wrap, active);
    end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({count, sel, tick, wrap, active} !== 8'd0) begin
      bad++;
      $display("FAIL async_reset_idle: got count=%0d sel=%0d tick=%b wrap=%b active=%b, want all 0",
               count, sel, tick, wrap, active);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    total++;
    if (count !== 3'd1 || tick !== 1'b1 || active !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_step: got count=%0d tick=%b active=%b, want count=1 tick=1 active=0",
               count, tick, active);
    end
  endtask

  initial begin
    int s;
    test_reset();
    test_free_run(2'd1, 0, 32, 1'b0);
    test_free_run(2'd1, 2, 128, 1'b0);
    test_mode_change();
    test_speed_change();
    test_free_run(2'd0, 0, 10, 1'b0);
    test_drain_reraise();
    for (int r = 0; r < 6; r++) begin
      s = int'($urandom_range(0, 2));
      test_free_run(2'($urandom_range(0, 3)), s, int'($urandom_range(0, 20 * (1 << (1 + s)))), 1'b1);
    end
    mode = 2'd0;
    @(negedge clk);
    test_manual_step(sel === 2'bxx ? 2'd0 : sel);
    test_step_with_run();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
